mem_responder: RTL and testbench



---
 rtl/mem_if_pkg.sv | 26 ++
 rtl/switch_sync.sv | 24 ++
 rtl/mem_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and defaults for the SLC-3 memory responder
package mem_if_pkg;

  // Access sequencer states
  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    WR_WAIT,
    WR_DONE,
    ERR
  } state_t;

  localparam int          DEF_ADDR_W    = 16;
  localparam int          DEF_DATA_W    = 16;
  localparam int          DEF_MEM_WORDS = 1024;
  localparam int          DEF_READ_LAT  = 4;
  localparam int          DEF_WRITE_LAT = 4;
  localparam logic [15:0] DEF_IO_ADDR   = 16'hFFFF;

  // Used to size the shared latency counter for whichever latency is longer
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/switch_sync.sv
// rtl/switch_sync.sv - two-flop synchroniser for the asynchronous board switches
module switch_sync #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] meta_q;

  // First flop may go metastable; second flop presents a settled value
  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta_q <= '0;
      synced <= '0;
    end else begin
      meta_q <= raw;
      synced <= meta_q;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word memory plus switch/hex I/O location for the SLC-3
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                MEM_WORDS = DEF_MEM_WORDS,
  parameter int                READ_LAT  = DEF_READ_LAT,
  parameter int                WRITE_LAT = DEF_WRITE_LAT,
  parameter logic [ADDR_W-1:0] IO_ADDR   = ADDR_W'(DEF_IO_ADDR)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Data_from_CPU,
  input  logic [DATA_W-1:0] Switches,
  output logic [DATA_W-1:0] Data_to_CPU,
  output logic              Ready,
  output logic [DATA_W-1:0] Hex_out,
  output logic              Err
);

  localparam int CNT_W = $clog2(max_int(READ_LAT, WRITE_LAT) + 1);
  localparam int IDX_W = $clog2(MEM_WORDS);

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] hex_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [DATA_W-1:0] sw_sync;

  // Sequencer control strobes, decoded in the next-state process
  logic capture;
  logic load_rd;
  logic commit_wr;
  logic set_err;

  // Address/data of the access in flight; cycle 1 uses the live bus
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] eff_wdata;
  logic              in_mem;
  logic              is_io;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  switch_sync #(
    .WIDTH(DATA_W)
  ) u_switch_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .raw   (Switches),
    .synced(sw_sync)
  );

  // Select captured or live address so cycle-1 completions (short latencies) still work
  always_comb begin
    eff_addr  = capture ? ADDR : addr_q;
    eff_wdata = capture ? Data_from_CPU : wdata_q;
    in_mem    = 32'(eff_addr) < 32'(MEM_WORDS);
    is_io     = !in_mem && (eff_addr == IO_ADDR);
    idx       = eff_addr[IDX_W-1:0];
    if (in_mem) begin
      rd_word = mem[idx];
    end else if (is_io) begin
      rd_word = sw_sync;
    end else begin
      rd_word = '0;
    end
  end

  // State register and latency counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: strobe protocol, latency counting and error detection
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    capture   = 1'b0;
    load_rd   = 1'b0;
    commit_wr = 1'b0;
    set_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Mem_OE && Mem_WE) begin
          state_d = ERR;
          set_err = 1'b1;
        end else if (Mem_OE) begin
          capture = 1'b1;
          cnt_d   = CNT_W'(1);
          if (READ_LAT == 2) begin
            load_rd = 1'b1;
            state_d = RD_DONE;
          end else begin
            state_d = RD_WAIT;
          end
        end else if (Mem_WE) begin
          capture = 1'b1;
          cnt_d   = CNT_W'(1);
          if (WRITE_LAT == 1) begin
            commit_wr = 1'b1;
            state_d   = WR_DONE;
          end else begin
            state_d = WR_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (Mem_WE) begin
          state_d = ERR;
          set_err = 1'b1;
        end else if (!Mem_OE) begin
          state_d = IDLE;
          set_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // cnt_q counts completed strobe cycles, so this is cycle READ_LAT-1
          if (cnt_q == CNT_W'(READ_LAT - 2)) begin
            load_rd = 1'b1;
            state_d = RD_DONE;
          end
        end
      end
      RD_DONE: begin
        if (Mem_WE) begin
          state_d = ERR;
          set_err = 1'b1;
        end else if (!Mem_OE) begin
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        if (Mem_OE) begin
          state_d = ERR;
          set_err = 1'b1;
        end else if (!Mem_WE) begin
          state_d = IDLE;
          set_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Cycle WRITE_LAT: the strobe has been held long enough to commit
          if (cnt_q == CNT_W'(WRITE_LAT - 1)) begin
            commit_wr = 1'b1;
            state_d   = WR_DONE;
          end
        end
      end
      WR_DONE: begin
        if (Mem_OE) begin
          state_d = ERR;
          set_err = 1'b1;
        end else if (!Mem_WE) begin
          state_d = IDLE;
        end
      end
      ERR: begin
        if (!Mem_OE && !Mem_WE) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: Ready only while the completing strobe is still held
  always_comb begin
    Ready       = ((state_q == RD_DONE) && Mem_OE) || ((state_q == WR_DONE) && Mem_WE);
    Data_to_CPU = data_q;
    Hex_out     = hex_q;
    Err         = err_q;
  end

  // Datapath registers: captured request, read data, display and sticky error
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      hex_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (capture) begin
        addr_q  <= ADDR;
        wdata_q <= Data_from_CPU;
      end
      if (load_rd) begin
        data_q <= rd_word;
      end
      if (commit_wr && is_io) begin
        hex_q <= eff_wdata;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  // Word array; not reset, and a reset coinciding with commit drops the write
  always_ff @(posedge Clk) begin
    if (!Reset && commit_wr && in_mem) begin
      mem[idx] <= eff_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Mem_OE = 1'b0;
  logic        Mem_WE = 1'b0;
  logic [15:0] ADDR = '0;
  logic [15:0] Data_from_CPU = '0;
  logic [15:0] Switches = '0;
  logic [15:0] Data_to_CPU;
  logic        Ready;
  logic [15:0] Hex_out;
  logic        Err;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  mem_responder dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Mem_OE       (Mem_OE),
    .Mem_WE       (Mem_WE),
    .ADDR         (ADDR),
    .Data_from_CPU(Data_from_CPU),
    .Switches     (Switches),
    .Data_to_CPU  (Data_to_CPU),
    .Ready        (Ready),
    .Hex_out      (Hex_out),
    .Err          (Err)
  );

  // One bus cycle: drive just after the rising edge, return at the falling edge
  task automatic step(input logic rst, input logic oe, input logic we,
                      input logic [15:0] a, input logic [15:0] d);
    @(posedge Clk);
    #1;
    Reset = rst; Mem_OE = oe; Mem_WE = we; ADDR = a; Data_from_CPU = d;
    @(negedge Clk);
  endtask

  task automatic write_word(input logic [15:0] a, input logic [15:0] d);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, a, d);
    step(1'b0, 1'b0, 1'b0, a, d);
  endtask

  task automatic read_word(input logic [15:0] a);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, a, 16'h0000);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    vectors++; if (Data_to_CPU !== 16'h0000) begin miscompares++; $display("FAIL reset_data: got %h want 0000", Data_to_CPU); end
    vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", Ready); end
    vectors++; if (Hex_out !== 16'h0000) begin miscompares++; $display("FAIL reset_hex: got %h want 0000", Hex_out); end
    vectors++; if (Err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", Err); end
    idle();
  endtask

  task automatic test_write_read();
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'h0012, 16'hBEEF);
      if (i == 4) begin
        vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL wr_ready_c4: got %b want 0", Ready); end
      end
      if (i == 5) begin
        vectors++; if (Ready !== 1'b1) begin miscompares++; $display("FAIL wr_ready_c5: got %b want 1", Ready); end
      end
    end
    idle();
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0012, 16'h0000);
      if (i == 3) begin
        vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL rd_ready_c3: got %b want 0", Ready); end
      end
    end
    vectors++; if (Ready !== 1'b1) begin miscompares++; $display("FAIL rd_ready_c4: got %b want 1", Ready); end
    vectors++; if (Data_to_CPU !== 16'hBEEF) begin miscompares++; $display("FAIL rd_data: got %h want BEEF", Data_to_CPU); end
    vectors++; if (Err !== 1'b0) begin miscompares++; $display("FAIL wr_rd_err: got %b want 0", Err); end
    idle();
  endtask

  task automatic test_io_and_map();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h00A5);
    vectors++; if (Hex_out !== 16'h0000) begin miscompares++; $display("FAIL hex_before_commit: got %h want 0000", Hex_out); end
    idle();
    vectors++; if (Hex_out !== 16'h00A5) begin miscompares++; $display("FAIL hex_after_commit: got %h want 00A5", Hex_out); end
    Switches = 16'h0F0F;
    idle(); idle(); idle();
    read_word(16'hFFFF);
    vectors++; if (Data_to_CPU !== 16'h0F0F) begin miscompares++; $display("FAIL io_read: got %h want 0F0F", Data_to_CPU); end
    vectors++; if (Ready !== 1'b1) begin miscompares++; $display("FAIL io_ready: got %b want 1", Ready); end
    idle();
    // Last array word, word 0, and the first unmapped address just past the array
    write_word(16'h03FF, 16'h7E7E);
    write_word(16'h0000, 16'h2222);
    write_word(16'h0400, 16'h1111);
    read_word(16'h03FF);
    vectors++; if (Data_to_CPU !== 16'h7E7E) begin miscompares++; $display("FAIL last_word: got %h want 7E7E", Data_to_CPU); end
    idle();
    read_word(16'h0400);
    vectors++; if (Data_to_CPU !== 16'h0000) begin miscompares++; $display("FAIL unmapped_read: got %h want 0000", Data_to_CPU); end
    vectors++; if (Ready !== 1'b1) begin miscompares++; $display("FAIL unmapped_ready: got %b want 1", Ready); end
    idle();
    read_word(16'h0000);
    vectors++; if (Data_to_CPU !== 16'h2222) begin miscompares++; $display("FAIL no_alias: got %h want 2222", Data_to_CPU); end
    idle();
  endtask

  task automatic test_long_oe();
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0012, 16'h0000);
      vectors++; if (Ready !== (i >= 4)) begin miscompares++; $display("FAIL long_ready_c%0d: got %b want %b", i, Ready, (i >= 4)); end
      if (i >= 4) begin
        vectors++; if (Data_to_CPU !== 16'hBEEF) begin miscompares++; $display("FAIL long_data_c%0d: got %h want BEEF", i, Data_to_CPU); end
      end
    end
    idle();
    vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL long_ready_drop: got %b want 0", Ready); end
    idle();
    vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL long_ready_idle: got %b want 0", Ready); end
  endtask

  task automatic test_early_abort();
    write_word(16'h0020, 16'h5555);
    vectors++; if (Err !== 1'b0) begin miscompares++; $display("FAIL abort_err_pre: got %b want 0", Err); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'h0020, 16'h1234);
    idle();
    idle();
    vectors++; if (Err !== 1'b1) begin miscompares++; $display("FAIL abort_err: got %b want 1", Err); end
    vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL abort_ready: got %b want 0", Ready); end
    read_word(16'h0020);
    vectors++; if (Data_to_CPU !== 16'h5555) begin miscompares++; $display("FAIL abort_readback: got %h want 5555", Data_to_CPU); end
    idle();
  endtask

  task automatic test_protocol_error();
    write_word(16'h0030, 16'hAAAA);
    step(1'b0, 1'b1, 1'b1, 16'h0030, 16'h9999);
    step(1'b0, 1'b1, 1'b1, 16'h0030, 16'h9999);
    vectors++; if (Err !== 1'b1) begin miscompares++; $display("FAIL proto_err: got %b want 1", Err); end
    vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL proto_ready: got %b want 0", Ready); end
    idle();
    idle();
    read_word(16'h0030);
    vectors++; if (Data_to_CPU !== 16'hAAAA) begin miscompares++; $display("FAIL proto_readback: got %h want AAAA", Data_to_CPU); end
    vectors++; if (Ready !== 1'b1) begin miscompares++; $display("FAIL proto_ready_after: got %b want 1", Ready); end
    vectors++; if (Err !== 1'b1) begin miscompares++; $display("FAIL proto_err_sticky: got %b want 1", Err); end
    idle();
  endtask

  task automatic test_reset_mid_write();
    write_word(16'h0005, 16'h0505);
    step(1'b0, 1'b0, 1'b1, 16'h0005, 16'hDEAD);
    step(1'b0, 1'b0, 1'b1, 16'h0005, 16'hDEAD);
    step(1'b1, 1'b0, 1'b1, 16'h0005, 16'hDEAD);
    idle();
    vectors++; if (Data_to_CPU !== 16'h0000) begin miscompares++; $display("FAIL rst_mid_data: got %h want 0000", Data_to_CPU); end
    vectors++; if (Ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ready: got %b want 0", Ready); end
    vectors++; if (Hex_out !== 16'h0000) begin miscompares++; $display("FAIL rst_mid_hex: got %h want 0000", Hex_out); end
    vectors++; if (Err !== 1'b0) begin miscompares++; $display("FAIL rst_mid_err: got %b want 0", Err); end
    read_word(16'h0005);
    vectors++; if (Data_to_CPU !== 16'h0505) begin miscompares++; $display("FAIL rst_mid_readback: got %h want 0505", Data_to_CPU); end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_io_and_map();
    test_long_oe();
    test_early_abort();
    test_protocol_error();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
